// File: rtl/tgc_mode_sequencer_pkg.sv
// rtl/tgc_mode_sequencer_pkg.sv - mode codes shared with the downstream mode-select mux
package tgc_mode_sequencer_pkg;

    // Encoding doubles as the tgc_out code; must match the mux decode.
    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_A    = 2'b01,
        MODE_B    = 2'b10
    } tgc_mode_e;

    localparam int ROUND_W = 4;

endpackage

// File: rtl/tgc_mode_sequencer_button_edge.sv
// rtl/tgc_mode_sequencer_button_edge.sv - 1-bit rising-edge detector for operator inputs
module button_edge (
    input  logic clock,
    input  logic reset,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;
    logic r_armed;

    // r_armed stays low until the input is seen low after reset, so a level
    // already held through reset never counts as a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev <= i_level;
            if (!i_level) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_rise = i_level & ~r_prev & r_armed;

endmodule

// File: rtl/tgc_mode_sequencer.sv
// rtl/tgc_mode_sequencer.sv - load / Mode A / Mode B sequencer with phase timer and round counter
module tgc_mode_sequencer
    import tgc_mode_sequencer_pkg::*;
#(
    parameter int TIMER_W       = 8,
    parameter int MODE_A_CYCLES = 8,
    parameter int MODE_B_CYCLES = 4,
    parameter int ROUNDS        = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               control_button,
    input  logic               load_ready,
    output logic [1:0]         tgc_out,
    output logic               mode_change,
    output logic [TIMER_W-1:0] time_left,
    output logic [ROUND_W-1:0] round_count,
    output logic               run_done
);

    localparam logic [TIMER_W-1:0] LP_A_LOAD = TIMER_W'(MODE_A_CYCLES);
    localparam logic [TIMER_W-1:0] LP_B_LOAD = TIMER_W'(MODE_B_CYCLES);
    localparam logic [TIMER_W-1:0] LP_ONE    = TIMER_W'(1);
    localparam logic [ROUND_W-1:0] LP_ROUNDS = ROUND_W'(ROUNDS);

    tgc_mode_e          r_state;
    tgc_mode_e          w_next_state;
    logic [TIMER_W-1:0] r_time;
    logic [TIMER_W-1:0] w_next_time;
    logic [ROUND_W-1:0] r_round;
    logic [ROUND_W-1:0] w_next_round;
    logic [ROUND_W-1:0] w_round_inc;
    logic               r_mode_change;
    logic               w_next_mode_change;
    logic               r_run_done;
    logic               w_next_run_done;
    logic               w_event;
    logic               w_phase_end;

    button_edge u_button_edge (
        .clock   (clock),
        .reset   (reset),
        .i_level (control_button),
        .o_rise  (w_event)
    );

    assign w_phase_end = (r_time == LP_ONE) || w_event;
    assign w_round_inc = (r_round == LP_ROUNDS) ? r_round : r_round + ROUND_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= MODE_LOAD;
            r_time        <= '0;
            r_round       <= '0;
            r_mode_change <= 1'b0;
            r_run_done    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_time        <= w_next_time;
            r_round       <= w_next_round;
            r_mode_change <= w_next_mode_change;
            r_run_done    <= w_next_run_done;
        end
    end

    always_comb begin
        w_next_state       = r_state;
        w_next_time        = r_time;
        w_next_round       = r_round;
        w_next_mode_change = 1'b0;
        w_next_run_done    = 1'b0;
        case (r_state)
            MODE_LOAD: begin
                if (w_event && load_ready) begin
                    w_next_state       = MODE_A;
                    w_next_time        = LP_A_LOAD;
                    w_next_round       = '0;
                    w_next_mode_change = 1'b1;
                end
            end
            MODE_A: begin
                if (w_phase_end) begin
                    w_next_state       = MODE_B;
                    w_next_time        = LP_B_LOAD;
                    w_next_mode_change = 1'b1;
                end else begin
                    w_next_time = r_time - LP_ONE;
                end
            end
            MODE_B: begin
                if (w_phase_end) begin
                    w_next_round       = w_round_inc;
                    w_next_mode_change = 1'b1;
                    if (w_round_inc == LP_ROUNDS) begin
                        w_next_state    = MODE_LOAD;
                        w_next_time     = '0;
                        w_next_run_done = 1'b1;
                    end else begin
                        w_next_state = MODE_A;
                        w_next_time  = LP_A_LOAD;
                    end
                end else begin
                    w_next_time = r_time - LP_ONE;
                end
            end
            default: begin
                w_next_state       = MODE_LOAD;
                w_next_time        = '0;
                w_next_mode_change = 1'b1;
            end
        endcase
    end

    assign tgc_out     = r_state;
    assign mode_change = r_mode_change;
    assign time_left   = r_time;
    assign round_count = r_round;
    assign run_done    = r_run_done;

endmodule
